// File: rtl/tri_fetch_seq_if.sv
// Reader request/response and downstream triangle stream for tri_fetch_seq.
// master = sequencer side; slave = reader plus intersector side.
interface tri_fetch_seq_if #(
  parameter int NDWORDS = 9
);
  localparam int BLOCKSZ = 32 * NDWORDS;

  logic [31:0]        tr_index;
  logic               tr_read;
  logic [BLOCKSZ-1:0] tr_data;
  logic               tr_ovalid;
  logic               tr_iready;

  logic [BLOCKSZ-1:0] tri_data;
  logic [31:0]        tri_id;
  logic               tri_last;
  logic               tri_valid;
  logic               tri_ready;

  modport master (
    output tr_index,
    output tr_read,
    input  tr_data,
    input  tr_ovalid,
    input  tr_iready,
    output tri_data,
    output tri_id,
    output tri_last,
    output tri_valid,
    input  tri_ready
  );

  modport slave (
    input  tr_index,
    input  tr_read,
    output tr_data,
    output tr_ovalid,
    output tr_iready,
    input  tri_data,
    input  tri_id,
    input  tri_last,
    input  tri_valid,
    output tri_ready
  );
endinterface

// File: rtl/tri_fetch_seq.sv
// Triangle sweep sequencer: walks 0..ntris-1 through the reader, streams blocks out.
// Define TRI_SEQ_STATS_EN to add the wait-cycle and handshake counters.
module tri_fetch_seq #(
  parameter int NDWORDS = 9
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [31:0]     ntris,
  output logic            busy,
  output logic            done,
`ifdef TRI_SEQ_STATS_EN
  output logic [31:0]     stat_wait_cycles,
  output logic [31:0]     stat_tris,
`endif
  tri_fetch_seq_if.master bus
);
  localparam int BLOCKSZ = 32 * NDWORDS;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t state;
  state_t state_d;

  logic [31:0]        idx;
  logic [31:0]        last_idx;
  logic [31:0]        id_q;
  logic [BLOCKSZ-1:0] data_q;
  logic               last_q;
  logic               valid_q;
  logic               done_q;

  logic accept;
  logic capture;
  logic fire;
  logic rd;

  assign accept  = (state == IDLE) && start;
  assign capture = (state == WAIT) && bus.tr_ovalid;
  assign fire    = (state == HOLD) && bus.tri_ready;

  always_comb begin
    state_d = state;
    rd      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && (ntris != 32'd0)) state_d = ISSUE;
      end
      ISSUE: begin
        // ovalid here may belong to the previous index
        rd = bus.tr_iready;
        if (bus.tr_iready) state_d = WAIT;
      end
      WAIT: begin
        rd = 1'b1;
        if (bus.tr_ovalid) state_d = HOLD;
      end
      HOLD: begin
        if (bus.tri_ready) state_d = last_q ? IDLE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // termination by equality keeps ntris = 2^32-1 legal
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      last_idx <= '0;
    end else if (accept && (ntris != 32'd0)) begin
      idx      <= '0;
      last_idx <= ntris - 32'd1;
    end else if (fire && !last_q) begin
      idx      <= idx + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (capture) begin
      data_q  <= bus.tr_data;
      id_q    <= idx;
      last_q  <= (idx == last_idx);
      valid_q <= 1'b1;
    end else if (fire) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else done_q <= (accept && (ntris == 32'd0))
                || (fire && last_q);
  end

`ifdef TRI_SEQ_STATS_EN
  logic [31:0] wait_cnt;
  logic [31:0] tris_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      tris_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
      tris_cnt <= '0;
    end else begin
      if ((state == WAIT) && (wait_cnt != '1))
        wait_cnt <= wait_cnt + 32'd1;
      if (fire && (tris_cnt != '1))
        tris_cnt <= tris_cnt + 32'd1;
    end
  end

  assign stat_wait_cycles = wait_cnt;
  assign stat_tris        = tris_cnt;
`endif

  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign bus.tr_index  = idx;
  assign bus.tr_read   = rd;
  assign bus.tri_data  = data_q;
  assign bus.tri_id    = id_q;
  assign bus.tri_last  = last_q;
  assign bus.tri_valid = valid_q;
endmodule

// File: tb/tb_tri_fetch_seq.sv
// Directed bench for tri_fetch_seq: reader model, output scoreboard, timing checks.
// Stats checks are active when TRI_SEQ_STATS_EN is defined.
module tb_tri_fetch_seq;
  localparam int NDW = 9;
  localparam int BS  = 32 * NDW;

  typedef struct {
    logic [31:0]   id;
    logic          last;
    logic [BS-1:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] ntris;
  logic        busy;
  logic        done;
`ifdef TRI_SEQ_STATS_EN
  logic [31:0] stat_wait_cycles;
  logic [31:0] stat_tris;
`endif

  tri_fetch_seq_if #(.NDWORDS(NDW)) bus();

  tri_fetch_seq #(.NDWORDS(NDW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .ntris            (ntris),
    .busy             (busy),
    .done             (done),
`ifdef TRI_SEQ_STATS_EN
    .stat_wait_cycles (stat_wait_cycles),
    .stat_tris        (stat_tris),
`endif
    .bus              (bus.master)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   e0    = 0;
  int   rd_exp;
  int   n_reads;
  int   n_done;
  int   lat_tab [16];
  bit   spur;
  bit   rd_clr;
  exp_t q [$];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [BS-1:0] pat(input logic [31:0] i);
    logic [BS-1:0] v;
    v = '0;
    for (int w = 0; w < NDW; w++)
      v[w*32 +: 32] = {8'(w), 8'hC3, i[15:0]};
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [BS-1:0] obs,
                     input logic [BS-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reader model: latency from lat_tab, optional spurious ovalid in ISSUE
  initial begin : reader
    logic [31:0] pidx;
    int          cnt;
    bit          pend;
    pend = 1'b0;
    cnt  = 0;
    pidx = '0;
    bus.tr_ovalid = 1'b0;
    bus.tr_data   = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.tr_ovalid = 1'b0;
      if (rd_clr) begin
        pend = 1'b0;
      end else if (pend) begin
        if (bus.tr_read) chk("rd_hold", bus.tr_index, pidx);
        cnt--;
        if (cnt <= 0) begin
          bus.tr_ovalid = 1'b1;
          bus.tr_data   = pat(pidx);
          pend          = 1'b0;
        end
      end else if (bus.tr_read) begin
        chk("rd_idx", bus.tr_index, rd_exp);
        rd_exp++;
        n_reads++;
        pend = 1'b1;
        pidx = bus.tr_index;
        cnt  = lat_tab[pidx[3:0]];
        if (spur) begin
          bus.tr_ovalid = 1'b1;
          bus.tr_data   = '1;
        end
      end
    end
  end

  // scoreboard on downstream handshakes
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (done) n_done++;
      if (bus.tri_valid && bus.tri_ready) begin
        total++;
        assert (q.size() > 0) else begin
          bad++;
          $error("FAIL sb_extra obs=id %0d exp=no output", bus.tri_id);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("sb_id", bus.tri_id, e.id);
          chk("sb_last", bus.tri_last, e.last);
          chk("sb_data", bus.tri_data, e.data);
        end
      end
    end
  end

  task automatic start_sweep(input logic [31:0] n, input int npush);
    rd_exp  = 0;
    n_reads = 0;
    n_done  = 0;
    for (int i = 0; i < npush; i++)
      q.push_back('{id: i, last: (i == n - 32'd1), data: pat(i)});
    @(negedge clk);
    start = 1'b1;
    ntris = n;
    @(negedge clk);
    start = 1'b0;
    ntris = $urandom;
    e0    = cyc;
  endtask

  task automatic wait_done(input string tag, output int c);
    int k;
    k = 0;
    #1;
    while (!done && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    c = cyc - e0 + 1;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    #1;
    while (!bus.tri_valid && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_valid"}, bus.tri_valid, 1'b1);
  endtask

  task automatic after_done(input string tag, input int nrd);
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_nreads"}, n_reads, nrd);
    chk({tag, "_sb_empty"}, q.size(), 0);
  endtask

  initial begin : main
    int c;
    for (int i = 0; i < 16; i++) lat_tab[i] = 1;
    spur          = 1'b0;
    rd_clr        = 1'b1;
    rd_exp        = 0;
    n_reads       = 0;
    n_done        = 0;
    reset_n       = 1'b0;
    start         = 1'b0;
    ntris         = '0;
    bus.tr_iready = 1'b1;
    bus.tri_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_read", bus.tr_read, 1'b0);
    chk("rst_index", bus.tr_index, 0);
    chk("rst_valid", bus.tri_valid, 1'b0);
    chk("rst_last", bus.tri_last, 1'b0);
    chk("rst_id", bus.tri_id, 0);
    chk("rst_data", bus.tri_data, 0);
`ifdef TRI_SEQ_STATS_EN
    chk("rst_stat_wait", stat_wait_cycles, 0);
    chk("rst_stat_tris", stat_tris, 0);
`endif
    reset_n = 1'b1;
    rd_clr  = 1'b0;

    // three triangles, cache hits, no backpressure
    start_sweep(3, 3);
    #1;
    chk("t1_busy", busy, 1'b1);
    wait_done("t1", c);
    chk("t1_latency", c, 10);
    after_done("t1", 3);

    // empty sweep
    start_sweep(0, 0);
    wait_done("t2", c);
    chk("t2_latency", c, 1);
    after_done("t2", 0);

    // reader not ready: ISSUE waits without requesting
    bus.tr_iready = 1'b0;
    start_sweep(1, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("t3_read_low", bus.tr_read, 1'b0);
      chk("t3_busy", busy, 1'b1);
      chk("t3_index", bus.tr_index, 0);
    end
    bus.tr_iready = 1'b1;
    wait_done("t3", c);
    chk("t3_latency", c, 7);
    after_done("t3", 1);

    // backpressure on index 0, 20-cycle miss on index 1
    lat_tab[1]    = 20;
    bus.tri_ready = 1'b0;
    start_sweep(2, 2);
    wait_valid("t4");
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_valid", bus.tri_valid, 1'b1);
      chk("t4_stall_id", bus.tri_id, 0);
      chk("t4_stall_data", bus.tri_data, pat(0));
      if (i < 4) begin
        @(negedge clk);
        #1;
      end
    end
    bus.tri_ready = 1'b1;
    wait_done("t4", c);
    after_done("t4", 2);
`ifdef TRI_SEQ_STATS_EN
    chk("t4_stat_wait", stat_wait_cycles, 21);
    chk("t4_stat_tris", stat_tris, 2);
`endif
    lat_tab[1] = 1;

    // spurious ovalid during ISSUE must not be captured
    spur       = 1'b1;
    lat_tab[0] = 2;
    start_sweep(1, 1);
    wait_done("t5", c);
    chk("t5_latency", c, 5);
    after_done("t5", 1);
    spur       = 1'b0;
    lat_tab[0] = 1;

    // start while busy is dropped
    start_sweep(3, 3);
    repeat (3) @(negedge clk);
    start = 1'b1;
    ntris = 9;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6", c);
    chk("t6_latency", c, 10);
    after_done("t6", 3);

    // huge count, reset while waiting on index 1, then a normal sweep
    lat_tab[1] = 10;
    start_sweep(32'hFFFF_FFFF, 1);
    repeat (7) @(negedge clk);
    #1;
    chk("t7_pre_read", bus.tr_read, 1'b1);
    chk("t7_pre_index", bus.tr_index, 1);
    chk("t7_pre_busy", busy, 1'b1);
    chk("t7_pre_sb", q.size(), 0);
    rd_clr  = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("t7_rst_busy", busy, 1'b0);
    chk("t7_rst_read", bus.tr_read, 1'b0);
    chk("t7_rst_index", bus.tr_index, 0);
    chk("t7_rst_valid", bus.tri_valid, 1'b0);
    chk("t7_rst_id", bus.tri_id, 0);
    chk("t7_rst_data", bus.tri_data, 0);
`ifdef TRI_SEQ_STATS_EN
    chk("t7_rst_stat_wait", stat_wait_cycles, 0);
`endif
    q.delete();
    lat_tab[1] = 1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd_clr  = 1'b0;
    start_sweep(1, 1);
    wait_done("t8", c);
    chk("t8_latency", c, 4);
    after_done("t8", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tri_fetch_seq.md
# tri_fetch_seq

Sweep sequencer that sits directly upstream of the triangle reader. On a start pulse it walks triangle indices 0..ntris-1 and drives the reader's read/index request, holding each request until data is returned. It then presents every returned triangle block, tagged with its index and a last flag, to the downstream intersector over a valid/ready handshake, and pulses done once the final triangle has been accepted.

## Interface
Parameters:
- NDWORDS, 9: 32-bit words per triangle record.
- BLOCKSZ, 32*NDWORDS: triangle block width; localparam, not overridable.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep; ignored while busy=1.
- ntris  in  32  triangle count; sampled only on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sweep ends.
- tr_index  out  32  index to the triangle reader.
- tr_read  out  1  read request to the triangle reader.
- tr_data  in  BLOCKSZ  triangle block from the reader.
- tr_ovalid  in  1  reader output valid.
- tr_iready  in  1  reader input ready.
- tri_data  out  BLOCKSZ  registered triangle block to downstream.
- tri_id  out  32  index of tri_data.
- tri_last  out  1  tri_id == ntris-1.
- tri_valid  out  1  downstream valid.
- tri_ready  in  1  downstream ready.

## Operation
The FSM has states IDLE, ISSUE, WAIT, HOLD.
- **IDLE:**
  - busy=0, tr_read=0.
  - start=1 with ntris=0: no reads are issued, and done pulses the next cycle.
  - start=1 with ntris>0: latch ntris, clear the index counter idx to 0, go to ISSUE.
- **ISSUE:**
  - tr_read = tr_iready (combinational); tr_index = idx.
  - When tr_iready=1, go to WAIT.
  - tr_ovalid is ignored in this state, because it may reflect the previous index.
- **WAIT:**
  - tr_read=1; tr_index=idx, held constant.
  - When tr_ovalid=1: register tri_data<=tr_data, tri_id<=idx, tri_last<=(idx==ntris-1), set tri_valid<=1, go to HOLD.
- **HOLD:**
  - tr_read=0; tri_valid stays high, and tri_data/tri_id/tri_last are stable.
  - When tri_ready=1:
    - tri_valid<=0.
    - If tri_last: done pulses, go to IDLE.
    - Otherwise: idx<=idx+1, go to ISSUE.

Arithmetic and boundary rules:
- idx is 32-bit and never wraps. Termination is by equality with ntris-1, so ntris=2^32-1 is legal.
- tr_index changes only on ISSUE entry, never while tr_read=1 is being held.
- A start pulse while busy is dropped, and its ntris is not sampled.
- Reset mid-sweep: all state returns to IDLE immediately, and any outstanding reader request is abandoned. The reader must be reset by the same system reset.

Reset values:
- busy=0, done=0, tr_read=0, tr_index=0, tri_valid=0, tri_last=0, tri_id=0, tri_data=0.
- Stats counters (when compiled in) = 0.

## Timing
- start is accepted at edge 0. ISSUE occupies cycle 1, with tr_read high if tr_iready=1.
- Earliest tr_ovalid is in cycle 2 (reader cache hit). tri_valid goes high in cycle 3.
- With tri_ready held high, ISSUE for the next index is in cycle 4. Cache-hit throughput is therefore one triangle per 3 cycles.
- A cache miss extends WAIT by the SDRAM fill time. There is no timeout.
- done is registered and asserts in the cycle after the final HOLD handshake. busy falls in the same cycle done is high.
- tri_valid must not drop without tri_ready. Downstream backpressure of any length is legal.

## Configuration
- TRI_SEQ_STATS_EN defined:
  - Adds output stat_wait_cycles (32): counts cycles spent in WAIT.
  - Adds output stat_tris (32): counts HOLD handshakes.
  - Both clear on an accepted start, saturate at all-ones, and hold their value after done until the next start.
- Undefined: both ports and both counters are absent. Sequencing behaviour is identical either way.

## Test plan
- **ntris=3, reader returns ovalid one cycle after read, tri_ready tied 1:**
  - tr_index sequence 0,1,2; tri_id 0,1,2; tri_last only on id 2.
  - done pulses exactly once, 1 cycle after the third handshake; total 10 cycles from start.
- **ntris=0:** no tr_read ever asserted; done pulses the cycle after start; busy stays 0.
- **ntris=2, miss on index 1 (ovalid after 20 cycles), tri_ready low for 5 cycles on index 0:**
  - tri_data and tri_id stay stable during the stall.
  - tr_index holds 1 for the full wait.
  - stat_wait_cycles=21 (stats build).
- **tr_ovalid forced high during ISSUE:** it must not be captured; data is captured only from WAIT.
- **start pulsed again mid-sweep with ntris=9:** ignored; the original count completes.
- **reset_n asserted low while in WAIT:** outputs return to 0 asynchronously. A new start with ntris=1 completes normally.
